// File: rtl/multiplexor_display.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, tear-free snapshot of
// the inputs per full scan, leading-zero blanking and anti-ghosting dark window.
module multiplexor_display #(
    parameter int N_DIGITOS       = 4,
    parameter int CICLOS_REFRESCO = 100000,
    parameter int CICLOS_APAGADO  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*N_DIGITOS-1:0] valores,
    input  logic [N_DIGITOS-1:0]   puntos,
    input  logic                   habilitar,
    input  logic                   blanqueo_ceros,
    output logic [6:0]             catodo,
    output logic                   dp,
    output logic [N_DIGITOS-1:0]   anodo
);

    localparam int CW = (CICLOS_REFRESCO > 1) ? $clog2(CICLOS_REFRESCO) : 1;
    localparam int IW = $clog2(N_DIGITOS);

    localparam logic [CW-1:0] C_ULTIMO  = CW'(CICLOS_REFRESCO - 1);
    localparam logic [CW-1:0] C_APAGADO = CW'(CICLOS_APAGADO);
    localparam logic [IW-1:0] I_ULTIMO  = IW'(N_DIGITOS - 1);

    logic [CW-1:0]                 r_contador;
    logic [IW-1:0]                 r_indice;
    logic [N_DIGITOS-1:0][3:0]     r_snap_val;
    logic [N_DIGITOS-1:0]          r_snap_pts;
    logic                          r_snap_blq;
    logic                          r_carga_ini;

    logic                          w_tick;
    logic                          w_carga;
    logic [N_DIGITOS-1:0]          w_ceros_arriba;
    logic [3:0]                    w_digito;
    logic                          w_apagar;

    function automatic logic [6:0] decodificar(input logic [3:0] d);
        case (d)
            4'h0:    decodificar = 7'b0000001;
            4'h1:    decodificar = 7'b1001111;
            4'h2:    decodificar = 7'b0010010;
            4'h3:    decodificar = 7'b0000110;
            4'h4:    decodificar = 7'b1001100;
            4'h5:    decodificar = 7'b0100100;
            4'h6:    decodificar = 7'b0100000;
            4'h7:    decodificar = 7'b0001111;
            4'h8:    decodificar = 7'b0000000;
            4'h9:    decodificar = 7'b0000100;
            4'hA:    decodificar = 7'b1111110;
            default: decodificar = 7'b1111111;
        endcase
    endfunction

    assign w_tick   = habilitar && (r_contador == C_ULTIMO);
    // Snapshot refreshes only at the end of a full scan (or right after reset).
    assign w_carga  = r_carga_ini || (w_tick && (r_indice == I_ULTIMO));
    assign w_digito = r_snap_val[r_indice];

    // w_ceros_arriba[i]: digit i and every digit above it are zero.
    always_comb begin
        logic v_acc;
        v_acc          = 1'b1;
        w_ceros_arriba = '0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            v_acc             = v_acc && (r_snap_val[i] == 4'd0);
            w_ceros_arriba[i] = v_acc;
        end
    end

    assign w_apagar = r_snap_blq && (r_indice != '0) && w_ceros_arriba[r_indice];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_contador  <= '0;
            r_indice    <= '0;
            r_snap_val  <= '0;
            r_snap_pts  <= '0;
            r_snap_blq  <= 1'b0;
            r_carga_ini <= 1'b1;
            anodo       <= '1;
            catodo      <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            if (habilitar) begin
                if (r_contador == C_ULTIMO) begin
                    r_contador <= '0;
                    r_indice   <= (r_indice == I_ULTIMO) ? '0 : r_indice + 1'b1;
                end else begin
                    r_contador <= r_contador + 1'b1;
                end
            end

            r_carga_ini <= 1'b0;
            if (w_carga) begin
                r_snap_val <= valores;
                r_snap_pts <= puntos;
                r_snap_blq <= blanqueo_ceros;
            end

            if (!habilitar || (r_contador < C_APAGADO)) begin
                anodo  <= '1;
                catodo <= 7'b1111111;
                dp     <= 1'b1;
            end else begin
                anodo  <= ~(N_DIGITOS'(1) << r_indice);
                catodo <= w_apagar ? 7'b1111111 : decodificar(w_digito);
                dp     <= ~r_snap_pts[r_indice];
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed bench for multiplexor_display with N=4, 8-cycle slots, 2 dark cycles.
module tb_multiplexor_display;

    localparam int N  = 4;
    localparam int CR = 8;
    localparam int CA = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [4*N-1:0] valores;
    logic [N-1:0] puntos;
    logic         habilitar;
    logic         blanqueo_ceros;
    logic [6:0]   catodo;
    logic         dp;
    logic [N-1:0] anodo;

    int n_ok  = 0;
    int n_tot = 0;

    localparam logic [11:0] OSCURO = {4'b1111, 7'b1111111, 1'b1};

    always #5 clk = ~clk;

    multiplexor_display #(
        .N_DIGITOS      (N),
        .CICLOS_REFRESCO(CR),
        .CICLOS_APAGADO (CA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valores       (valores),
        .puntos        (puntos),
        .habilitar     (habilitar),
        .blanqueo_ceros(blanqueo_ceros),
        .catodo        (catodo),
        .dp            (dp),
        .anodo         (anodo)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tot++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got an=%b cat=%b dp=%b, expected an=%b cat=%b dp=%b",
                      tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    // One full slot starting at contador=0: two dark cycles, then six lit ones.
    task automatic ver_slot(input string tag, input logic [3:0] an,
                            input logic [6:0] cat, input logic p);
        for (int c = 0; c < CR; c++) begin
            paso();
            if (c < CA) chk(tag, {anodo, catodo, dp}, OSCURO);
            else        chk(tag, {anodo, catodo, dp}, {an, cat, p});
        end
    endtask

    initial begin
        rst            = 1'b1;
        habilitar      = 1'b1;
        valores        = 16'h1234;
        puntos         = 4'b0000;
        blanqueo_ceros = 1'b0;
        repeat (3) paso();
        chk("reset", {anodo, catodo, dp}, OSCURO);

        // Scan 1: 1234, digit 0 rightmost
        rst = 1'b0;
        ver_slot("s1_d0", 4'b1110, 7'b1001100, 1'b1);
        ver_slot("s1_d1", 4'b1101, 7'b0000110, 1'b1);
        ver_slot("s1_d2", 4'b1011, 7'b0010010, 1'b1);
        ver_slot("s1_d3", 4'b0111, 7'b1001111, 1'b1);

        // Scan 2: inputs change mid-scan, snapshot must hold
        ver_slot("s2_d0", 4'b1110, 7'b1001100, 1'b1);
        valores = 16'h5678;
        ver_slot("s2_d1", 4'b1101, 7'b0000110, 1'b1);
        ver_slot("s2_d2", 4'b1011, 7'b0010010, 1'b1);
        ver_slot("s2_d3", 4'b0111, 7'b1001111, 1'b1);

        // Scan 3: 5678 now visible; queue 0070 with blanking
        valores        = 16'h0070;
        blanqueo_ceros = 1'b1;
        ver_slot("s3_d0", 4'b1110, 7'b0000000, 1'b1);
        ver_slot("s3_d1", 4'b1101, 7'b0001111, 1'b1);
        ver_slot("s3_d2", 4'b1011, 7'b0100000, 1'b1);
        ver_slot("s3_d3", 4'b0111, 7'b0100100, 1'b1);

        // Scan 4: leading-zero blanking of 0070
        valores = 16'h0000;
        puntos  = 4'b0100;
        ver_slot("s4_d0", 4'b1110, 7'b0000001, 1'b1);
        ver_slot("s4_d1", 4'b1101, 7'b0001111, 1'b1);
        ver_slot("s4_d2", 4'b1011, 7'b1111111, 1'b1);
        ver_slot("s4_d3", 4'b0111, 7'b1111111, 1'b1);

        // Scan 5: all zeros, digit 0 kept, blanked digit 2 keeps its dp
        valores        = 16'hFA09;
        puntos         = 4'b0010;
        blanqueo_ceros = 1'b0;
        ver_slot("s5_d0", 4'b1110, 7'b0000001, 1'b1);
        ver_slot("s5_d1", 4'b1101, 7'b1111111, 1'b1);
        ver_slot("s5_d2", 4'b1011, 7'b1111111, 1'b0);
        ver_slot("s5_d3", 4'b0111, 7'b1111111, 1'b1);

        // Scan 6: minus, blank code and dp
        ver_slot("s6_d0", 4'b1110, 7'b0000100, 1'b1);
        ver_slot("s6_d1", 4'b1101, 7'b0000001, 1'b0);
        ver_slot("s6_d2", 4'b1011, 7'b1111110, 1'b1);
        ver_slot("s6_d3", 4'b0111, 7'b1111111, 1'b1);

        // Scan 7: freeze mid-slot of digit 2, then resume with remaining count
        ver_slot("s7_d0", 4'b1110, 7'b0000100, 1'b1);
        ver_slot("s7_d1", 4'b1101, 7'b0000001, 1'b0);
        for (int c = 0; c < 4; c++) begin
            paso();
            chk("s7_d2_pre", {anodo, catodo, dp},
                (c < CA) ? OSCURO : {4'b1011, 7'b1111110, 1'b1});
        end
        habilitar = 1'b0;
        for (int c = 0; c < 20; c++) begin
            paso();
            chk("frozen", {anodo, catodo, dp}, OSCURO);
        end
        habilitar = 1'b1;
        for (int c = 0; c < 4; c++) begin
            paso();
            chk("s7_d2_post", {anodo, catodo, dp}, {4'b1011, 7'b1111110, 1'b1});
        end
        ver_slot("s7_d3", 4'b0111, 7'b1111111, 1'b1);

        // Reset mid-slot, then snapshot must reload on the first edge after release
        repeat (3) paso();
        chk("s8_d0_lit", {anodo, catodo, dp}, {4'b1110, 7'b0000100, 1'b1});
        rst     = 1'b1;
        valores = 16'h1234;
        puntos  = 4'b0000;
        paso();
        chk("rst_mid", {anodo, catodo, dp}, OSCURO);
        paso();
        rst = 1'b0;
        ver_slot("r_d0", 4'b1110, 7'b1001100, 1'b1);
        ver_slot("r_d1", 4'b1101, 7'b0000110, 1'b1);

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
